// File: rtl/sumador_serie_n.sv
// -----------------------------------------------------------------------------
// sumador_serie_n
//
// Bit-serial adder/subtractor. One full-adder cell and a carry flop process
// two WIDTH-bit operands LSB first, one bit per enabled clock.
//
//   add : sum = a + b + cin    (cout = carry out of the MSB)
//   sub : sum = a - b - cin    (cout = 1 means "no borrow")
//   ovf : two's-complement overflow of the selected operation
//
// Ports
//   clk    in   system clock, rising edge
//   rst_n  in   asynchronous active-low reset
//   ena    in   clock enable; low freezes every register
//   start  in   request, sampled only while idle with ena=1
//   sub    in   0 = add, 1 = subtract; latched at start
//   cin    in   carry-in (add) / borrow-in (sub); latched at start
//   a, b   in   WIDTH-bit operands; latched at start
//   busy   out  operation in flight (registered status)
//   done   out  result just became valid (registered status)
//   sum    out  WIDTH-bit result register, modulo 2^WIDTH
//   cout   out  raw carry out of the MSB
//   ovf    out  signed overflow flag
//
// Timing: start sampled at enabled edge k -> busy from edge k+1, done and
// the result flags from edge k+WIDTH+1, next start accepted at edge
// k+WIDTH+2. Disabled (ena=0) cycles stretch every interval one for one.
// -----------------------------------------------------------------------------
module sumador_serie_n #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic             start,
  input  logic             sub,
  input  logic             cin,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int unsigned      CNT_W    = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  if (WIDTH < 1 || WIDTH > 32) begin : g_width_check
    $error("sumador_serie_n: WIDTH must lie in 1..32");
  end

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Output of the single full-adder cell.
  typedef struct packed {
    logic carry;
    logic s;
  } fa_t;

  function automatic fa_t full_add(input logic x, input logic y, input logic c);
    fa_t r;
    r.s     = x ^ y ^ c;
    r.carry = (x & y) | (x & c) | (y & c);
    return r;
  endfunction

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q,  a_sh_d;    // operand A, consumed LSB first
  logic [WIDTH-1:0] b_sh_q,  b_sh_d;    // operand B (pre-inverted for sub)
  logic [WIDTH-1:0] res_q,   res_d;     // result bits enter at the MSB
  logic             carry_q, carry_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;     // bit index being processed
  logic [WIDTH-1:0] sum_q,   sum_d;
  logic             cout_q,  cout_d;
  logic             ovf_q,   ovf_d;
  logic             busy_q,  busy_d;
  logic             done_q,  done_d;

  fa_t              fa;
  logic [WIDTH-1:0] res_shift;

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every variable gets a default first so no path can infer a latch.
    state_d = state_q;
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    res_d   = res_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    busy_d  = busy_q;
    done_d  = done_q;

    fa        = full_add(a_sh_q[0], b_sh_q[0], carry_q);
    // Concatenate-then-shift keeps this legal for WIDTH=1 as well.
    res_shift = WIDTH'({fa.s, res_q} >> 1);

    if (ena) begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            // Subtraction is a + ~b + 1 - borrow_in, so the initial carry
            // is the inverted borrow.
            a_sh_d  = a;
            b_sh_d  = sub ? ~b : b;
            carry_d = cin ^ sub;
            cnt_d   = '0;
            state_d = ST_RUN;
          end
        end

        ST_RUN: begin
          a_sh_d  = a_sh_q >> 1;
          b_sh_d  = b_sh_q >> 1;
          res_d   = res_shift;
          carry_d = fa.carry;
          cnt_d   = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_LAST) begin
            // Processing the MSB: carry_q is the carry into the MSB and
            // fa.carry the carry out of it; they differ exactly on signed
            // overflow.
            sum_d   = res_shift;
            cout_d  = fa.carry;
            ovf_d   = carry_q ^ fa.carry;
            state_d = ST_DONE;
          end
        end

        ST_DONE: begin
          state_d = ST_IDLE;
        end

        default: begin
          state_d = ST_IDLE;
        end
      endcase

      // Status flags are registered from the current state, so they trail
      // the state by one enabled cycle; done coincides with the first cycle
      // in which a new start is accepted.
      busy_d = (state_q != ST_IDLE);
      done_d = (state_q == ST_DONE);
    end
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so all flops update
  // from the same pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      // NOTE: the operand/result shift registers are reset too; an aborted
      // operation must not leave stale bits visible to the next one.
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      res_q   <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      res_q   <= res_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign sum  = sum_q;
  assign cout = cout_q;
  assign ovf  = ovf_q;

endmodule

// File: tb/tb_sumador_serie_n.sv
// -----------------------------------------------------------------------------
// tb_sumador_serie_n
//
// Drives a WIDTH=8 and a WIDTH=1 instance of sumador_serie_n with directed
// vectors. A behavioural model (integer arithmetic plus a count of enabled
// edges since the accepted start) predicts busy/done/sum/cout/ovf, and one
// compare process checks both instances on every falling edge. Directed
// tests additionally pin latencies and results to hand-computed literals.
// -----------------------------------------------------------------------------
module tb_sumador_serie_n;

  localparam int W8      = 8;
  localparam int W1      = 1;
  localparam int PH_IDLE = 1000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;

  logic       ena8, start8, sub8, cin8;
  logic [7:0] a8, b8;
  logic       busy8, done8, cout8, ovf8;
  logic [7:0] sum8;

  logic       ena1, start1, sub1, cin1;
  logic [0:0] a1, b1;
  logic       busy1, done1, cout1, ovf1;
  logic [0:0] sum1;

  sumador_serie_n #(.WIDTH(W8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .ena(ena8), .start(start8), .sub(sub8),
    .cin(cin8), .a(a8), .b(b8), .busy(busy8), .done(done8), .sum(sum8),
    .cout(cout8), .ovf(ovf8)
  );

  sumador_serie_n #(.WIDTH(W1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .ena(ena1), .start(start1), .sub(sub1),
    .cin(cin1), .a(a1), .b(b1), .busy(busy1), .done(done1), .sum(sum1),
    .cout(cout1), .ovf(ovf1)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference arithmetic: returns {ovf, cout, sum[31:0]}.
  function automatic logic [33:0] ref_calc(input int w, input longint ua, input longint ub,
                                           input logic s, input logic c);
    longint m, r, sa, sb, sr;
    logic   co, ov;
    m  = longint'(1) << w;
    sa = (ua >= m / 2) ? ua - m : ua;
    sb = (ub >= m / 2) ? ub - m : ub;
    if (!s) begin
      r  = ua + ub + longint'(c);
      co = (r >= m);
      sr = sa + sb + longint'(c);
    end else begin
      r  = ua - ub - longint'(c);
      co = (r >= 0);
      sr = sa - sb - longint'(c);
    end
    ov = (sr < -(m / 2)) || (sr >= m / 2);
    return {ov, co, 32'(r & (m - 1))};
  endfunction

  // ---------------------------------------------------------------------------
  // Model: ph = enabled edges since the accepted start (PH_IDLE when none).
  // busy for ph in 1..W+1, done at ph == W+1, next start accepted once
  // ph >= W+1; results published when done rises.
  // ---------------------------------------------------------------------------
  int          ph8 = PH_IDLE;
  int          ph1 = PH_IDLE;
  logic [33:0] pend8 = '0, exp8 = '0;
  logic [33:0] pend1 = '0, exp1 = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ph8  <= PH_IDLE;
      exp8 <= '0;
    end else if (ena8) begin
      if (start8 && ph8 >= W8 + 1) begin
        ph8   <= 0;
        pend8 <= ref_calc(W8, longint'(a8), longint'(b8), sub8, cin8);
      end else begin
        if (ph8 == W8) exp8 <= pend8;
        ph8 <= (ph8 < PH_IDLE) ? ph8 + 1 : ph8;
      end
    end
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ph1  <= PH_IDLE;
      exp1 <= '0;
    end else if (ena1) begin
      if (start1 && ph1 >= W1 + 1) begin
        ph1   <= 0;
        pend1 <= ref_calc(W1, longint'(a1), longint'(b1), sub1, cin1);
      end else begin
        if (ph1 == W1) exp1 <= pend1;
        ph1 <= (ph1 < PH_IDLE) ? ph1 + 1 : ph1;
      end
    end
  end

  // Single compare process, sampling away from the active edge.
  always @(negedge clk) begin
    check("busy8", 64'(busy8), 64'(ph8 >= 1 && ph8 <= W8 + 1));
    check("done8", 64'(done8), 64'(ph8 == W8 + 1));
    if (ph8 >= W8 + 1)
      check("res8", 64'({ovf8, cout8, sum8}), 64'({exp8[33:32], exp8[7:0]}));
    check("busy1", 64'(busy1), 64'(ph1 >= 1 && ph1 <= W1 + 1));
    check("done1", 64'(done1), 64'(ph1 == W1 + 1));
    if (ph1 >= W1 + 1)
      check("res1", 64'({ovf1, cout1, sum1}), 64'({exp1[33:32], exp1[0]}));
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers; all run in the "1 ns after rising edge" phase.
  // ---------------------------------------------------------------------------
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Presents a request and returns just after the edge that samples it.
  task automatic start8_op(input logic s, input logic c, input logic [7:0] x, input logic [7:0] y);
    a8 = x; b8 = y; sub8 = s; cin8 = c; start8 = 1'b1;
    step(1);
    start8 = 1'b0;
  endtask

  // Advances until done8 is high; lat counts edges since the start edge.
  task automatic wait_done8(inout int lat);
    while (done8 !== 1'b1 && lat < 60) step_lat(lat);
  endtask

  task automatic step_lat(inout int lat);
    step(1);
    lat++;
  endtask

  task automatic op8(input string name, input logic s, input logic c,
                     input logic [7:0] x, input logic [7:0] y,
                     input logic [7:0] e_sum, input logic e_cout, input logic e_ovf);
    int lat;
    lat = 0;
    start8_op(s, c, x, y);
    wait_done8(lat);
    check({name, "_lat"},  64'(lat),   64'(W8 + 1));
    check({name, "_sum"},  64'(sum8),  64'(e_sum));
    check({name, "_cout"}, 64'(cout8), 64'(e_cout));
    check({name, "_ovf"},  64'(ovf8),  64'(e_ovf));
  endtask

  logic [1:0] fa_tab [8] = '{2'd0, 2'd1, 2'd1, 2'd2, 2'd1, 2'd2, 2'd2, 2'd3};

  initial begin
    int lat;
    int dcnt;

    rst_n = 1'b0;
    ena8 = 1'b1; start8 = 1'b0; sub8 = 1'b0; cin8 = 1'b0; a8 = '0; b8 = '0;
    ena1 = 1'b1; start1 = 1'b0; sub1 = 1'b0; cin1 = 1'b0; a1 = '0; b1 = '0;
    step(3);
    check("rst_sum8",  64'(sum8),  64'h0);
    check("rst_busy8", 64'(busy8), 64'h0);
    rst_n = 1'b1;
    step(2);

    // 1: basic add with busy timing
    lat = 0;
    start8_op(1'b0, 1'b0, 8'h35, 8'h4A);
    check("t1_busy_k", 64'(busy8), 64'h0);
    step_lat(lat);
    check("t1_busy_k1", 64'(busy8), 64'h1);
    wait_done8(lat);
    check("t1_lat",  64'(lat),  64'd9);
    check("t1_sum",  64'(sum8), 64'h7F);
    check("t1_cout", 64'(cout8), 64'h0);
    check("t1_ovf",  64'(ovf8), 64'h0);

    // 2: add wrap-around and signed overflow (back to back)
    op8("t2a", 1'b0, 1'b0, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b0);
    op8("t2b", 1'b0, 1'b0, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b1);

    // 3: subtraction
    op8("t3a", 1'b1, 1'b0, 8'h10, 8'h20, 8'hF0, 1'b0, 1'b0);
    op8("t3b", 1'b1, 1'b0, 8'h80, 8'h01, 8'h7F, 1'b1, 1'b1);
    op8("t3c", 1'b1, 1'b1, 8'h05, 8'h02, 8'h02, 1'b1, 1'b0);

    // 4: start while busy is ignored, then reset aborts mid-run
    lat = 0;
    start8_op(1'b0, 1'b0, 8'h01, 8'h01);
    step_lat(lat); step_lat(lat); step_lat(lat);
    a8 = 8'hAA; b8 = 8'h55; start8 = 1'b1;
    step_lat(lat);
    start8 = 1'b0;
    wait_done8(lat);
    check("t4_lat", 64'(lat),  64'd9);
    check("t4_sum", 64'(sum8), 64'h02);
    step(1);
    start8_op(1'b0, 1'b0, 8'h33, 8'h11);
    step(4);
    #1 rst_n = 1'b0;
    #1;
    check("t4_rst_busy", 64'(busy8), 64'h0);
    check("t4_rst_sum",  64'(sum8),  64'h0);
    check("t4_rst_cout", 64'(cout8), 64'h0);
    step(2);
    rst_n = 1'b1;
    dcnt = 0;
    repeat (15) begin
      step(1);
      if (done8 === 1'b1) dcnt++;
    end
    check("t4_no_done", 64'(dcnt), 64'd0);

    // 5: ena low mid-run and during done
    lat = 0;
    start8_op(1'b0, 1'b0, 8'h35, 8'h4A);
    step_lat(lat); step_lat(lat); step_lat(lat);
    ena8 = 1'b0;
    step_lat(lat); step_lat(lat); step_lat(lat);
    ena8 = 1'b1;
    wait_done8(lat);
    check("t5_lat", 64'(lat), 64'd12);
    dcnt = 1;
    ena8 = 1'b0;
    repeat (2) begin
      step(1);
      if (done8 === 1'b1) dcnt++;
    end
    ena8 = 1'b1;
    step(1);
    if (done8 === 1'b1) dcnt++;
    check("t5_done_len", 64'(dcnt), 64'd3);
    check("t5_sum",      64'(sum8), 64'h7F);

    // 6: WIDTH=1 exhaustive add, start held high for minimum spacing
    {a1, b1, cin1} = 3'd0;
    sub1   = 1'b0;
    start1 = 1'b1;
    step(1);
    for (int i = 0; i < 8; i++) begin
      step(1);
      check($sformatf("t6_%0d_done_k1", i), 64'(done1), 64'h0);
      step(1);
      check($sformatf("t6_%0d_done_k2", i), 64'(done1), 64'h1);
      check($sformatf("t6_%0d_fa", i), 64'({cout1, sum1}), 64'(fa_tab[i]));
      if (i < 7) {a1, b1, cin1} = 3'(i + 1);
      else       start1 = 1'b0;
      step(1);
    end

    step(4);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
